// File: rtl/enc4to2_registered.sv
`default_nettype none
// ============================================================================
//  Module   : enc4to2_registered
//  Purpose  : Registered 4:2 binary encoder. A one-hot request {d, c, b, a}
//             is converted to a 2-bit index. Three independent coding
//             styles (behavioural, dataflow, gate-level) compute the same
//             code in parallel. One register stage captures:
//               - the dataflow result,
//               - a one-hot validity flag,
//               - a flag that is set when the three styles disagree.
//
//  Ports    : clk      in   1  rising-edge clock
//             rst_n    in   1  asynchronous active-low reset
//             a        in   1  request line, index 0
//             b        in   1  request line, index 1
//             c        in   1  request line, index 2
//             d        in   1  request line, index 3
//             out0     out  1  registered encoded bit 0
//             out1     out  1  registered encoded bit 1
//             valid    out  1  registered; exactly one request line was high
//             mismatch out  1  registered; the three encoders disagreed
//
//  Revision : 1.0  initial release
// ============================================================================
module enc4to2_registered (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic out0,
    output logic out1,
    output logic valid,
    output logic mismatch
);

    // ------------------------------------------------------------------------
    // Request word, index 0 in the LSB
    // ------------------------------------------------------------------------
    logic [3:0] w_req;
    assign w_req = {d, c, b, a};

    // ------------------------------------------------------------------------
    // Behavioural encoder
    // The one-hot codes are listed explicitly. The default branch uses the
    // same OR equations as the other two styles, so all three agree for every
    // one of the 16 input patterns, including multi-hot and all-zero inputs.
    // ------------------------------------------------------------------------
    logic [1:0] w_beh_code;

    always_comb begin
        w_beh_code = 2'b00;
        case (w_req)
            4'b0001: w_beh_code = 2'b00;
            4'b0010: w_beh_code = 2'b01;
            4'b0100: w_beh_code = 2'b10;
            4'b1000: w_beh_code = 2'b11;
            default: w_beh_code = {c | d, b | d};
        endcase
    end

    // ------------------------------------------------------------------------
    // Dataflow encoder; this result is the one that gets registered
    // ------------------------------------------------------------------------
    logic [1:0] w_df_code;
    assign w_df_code[1] = c | d;
    assign w_df_code[0] = b | d;

    // ------------------------------------------------------------------------
    // Gate-level encoder
    // ------------------------------------------------------------------------
    wire w_gate_out1;
    wire w_gate_out0;

    or u_or_out1 (w_gate_out1, c, d);
    or u_or_out0 (w_gate_out0, b, d);

    logic [1:0] w_gate_code;
    assign w_gate_code = {w_gate_out1, w_gate_out0};

    // ------------------------------------------------------------------------
    // One-hot detect
    // A non-zero word with no second bit set: clearing the lowest set bit
    // (w_req & (w_req - 1)) leaves zero only for a single-bit word.
    // ------------------------------------------------------------------------
    logic [3:0] w_req_minus1;
    logic       w_one_hot;

    assign w_req_minus1 = w_req - 4'd1;
    assign w_one_hot    = (w_req != 4'd0) && ((w_req & w_req_minus1) == 4'd0);

    // ------------------------------------------------------------------------
    // Cross-check: any bit on which dataflow differs from either other style
    // ------------------------------------------------------------------------
    logic w_mismatch;
    assign w_mismatch = |((w_df_code ^ w_beh_code) | (w_df_code ^ w_gate_code));

    // ------------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------------
    logic r_out1;
    logic r_out0;
    logic r_valid;
    logic r_mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out1     <= 1'b0;
            r_out0     <= 1'b0;
            r_valid    <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_out1     <= w_df_code[1];
            r_out0     <= w_df_code[0];
            r_valid    <= w_one_hot;
            r_mismatch <= w_mismatch;
        end
    end

    assign out1     = r_out1;
    assign out0     = r_out0;
    assign valid    = r_valid;
    assign mismatch = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_enc4to2_registered.sv
`default_nettype none
// ============================================================================
//  Module   : tb_enc4to2_registered
//  Purpose  : Self-checking bench for enc4to2_registered. It uses a vector
//             table, hand-written reset sequences, an exhaustive sweep and a
//             randomized run. Expected values come from a behavioural model
//             of the encoding rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_enc4to2_registered;

    logic clk;
    logic rst_n;
    logic a, b, c, d;
    logic out0, out1, valid, mismatch;

    int n_checks;
    int n_errors;

    enc4to2_registered dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .out0     (out0),
        .out1     (out1),
        .valid    (valid),
        .mismatch (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;       // {d, c, b, a}
        logic [1:0] exp_code;  // {out1, out0}
        logic       exp_valid;
    } vec_t;

    // Reference model, built from the rules rather than the equations:
    //   index bit 1 is set when any request at index >= 2 is high,
    //   index bit 0 is set when any odd-indexed request is high,
    //   valid is set when exactly one request is high.
    // Result is packed as {out1, out0, valid, mismatch}.
    function automatic logic [3:0] model(input logic [3:0] req);
        int   ones;
        logic hi;
        logic odd;
        ones = 0;
        hi   = 1'b0;
        odd  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
                ones++;
                if (i >= 2)     hi  = 1'b1;
                if (i % 2 == 1) odd = 1'b1;
            end
        end
        return {hi, odd, (ones == 1), 1'b0};
    endfunction

    function automatic logic [3:0] observed();
        return {out1, out0, valid, mismatch};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got {out1,out0,valid,mismatch}=%b, expected %b", name, act, exp);
        end
    endtask

    // Drive a request between edges; check one edge later.
    task automatic apply_check(input string name, input logic [3:0] req, input logic [3:0] exp);
        @(negedge clk);
        {d, c, b, a} = req;
        @(posedge clk);
        #1;
        check(name, observed(), exp);
    endtask

    vec_t vecs[8];

    initial begin
        logic [3:0] r;

        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{4'b1000, 2'b11, 1'b1};  // d
        vecs[1] = '{4'b0100, 2'b10, 1'b1};  // c
        vecs[2] = '{4'b0010, 2'b01, 1'b1};  // b
        vecs[3] = '{4'b0001, 2'b00, 1'b1};  // a
        vecs[4] = '{4'b0000, 2'b00, 1'b0};  // all-zero
        vecs[5] = '{4'b0011, 2'b01, 1'b0};  // a&b
        vecs[6] = '{4'b0110, 2'b11, 1'b0};  // b&c
        vecs[7] = '{4'b1111, 2'b11, 1'b0};  // all ones

        // ---------------- reset with d held high ----------------
        rst_n = 1'b1;
        {d, c, b, a} = 4'b0000;
        #2;
        rst_n = 1'b0;
        d = 1'b1;
        #1;
        check("reset_assert", observed(), 4'b0000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", observed(), 4'b0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release_no_edge", observed(), 4'b0000);
        @(posedge clk);
        #1;
        check("first_edge_after_reset", observed(), 4'b1110);

        // ---------------- vector table ----------------
        foreach (vecs[i]) begin
            apply_check("table", vecs[i].req, {vecs[i].exp_code, vecs[i].exp_valid, 1'b0});
        end

        // ---------------- input change between edges ----------------
        apply_check("hold_setup", 4'b1000, 4'b1110);
        @(negedge clk);
        {d, c, b, a} = 4'b0001;
        #1;
        check("no_change_before_edge", observed(), 4'b1110);
        @(posedge clk);
        #1;
        check("change_at_edge", observed(), 4'b0010);

        // ---------------- exhaustive sweep ----------------
        for (int p = 0; p < 16; p++) begin
            r = p[3:0];
            apply_check("exhaustive", r, model(r));
        end

        // ---------------- asynchronous reset mid-stream ----------------
        for (int i = 0; i < 3; i++) begin
            apply_check("midstream_d", 4'b1000, 4'b1110);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", observed(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("async_reset_released", observed(), 4'b0000);
        @(posedge clk);
        #1;
        check("async_reset_recover", observed(), 4'b1110);

        // ---------------- randomized back-to-back ----------------
        for (int i = 0; i < 300; i++) begin
            r = 4'($urandom_range(0, 15));
            apply_check("random", r, model(r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
